// File: rtl/i2c_reg_target.sv
// I2C register target: 7-bit address, 8-bit pointer, DATA_BYTES-wide words, no clock stretching.
// Define I2C_TARGET_AUTOINC_EN to advance the pointer after every completed read or write word.
`timescale 1ns/1ps
module i2c_reg_target #(
    parameter int DATA_BYTES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [6:0]                chip_id,
    input  logic                      sda_in,
    input  logic                      scl_in,
    output logic                      sda_out,
    output logic                      scl_out,
    output logic                      sda_oen,
    output logic                      scl_oen,
    output logic [7:0]                reg_addr,
    input  logic [8*DATA_BYTES-1:0]   rd_data,
    output logic [8*DATA_BYTES-1:0]   wr_data,
    output logic                      wr_en,
    output logic                      busy,
    output logic                      done
);
    localparam int W = 8 * DATA_BYTES;
`ifdef I2C_TARGET_AUTOINC_EN
    localparam bit AutoInc = 1'b1;
`else
    localparam bit AutoInc = 1'b0;
`endif

    // state     | meaning
    // IDLE      | bus idle or not ours
    // ADDR      | shifting in address byte
    // ADDR_ACK  | acknowledging our address
    // PTR       | shifting in register pointer
    // PTR_ACK   | acknowledging pointer
    // WDATA     | shifting in write byte
    // WDATA_ACK | acknowledging write byte
    // RDATA     | shifting out read byte
    // RDATA_ACK | sampling master ACK/NACK
    // WAIT_STOP | ignoring bus until STOP/START
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic [W-1:0]   tx_q, tx_d;
    logic           rw_q, rw_d;
    logic           ack_q, ack_d;
    logic [7:0]     reg_addr_q, reg_addr_d;
    logic [W-1:0]   wr_data_q, wr_data_d;
    logic           wr_en_q, wr_en_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           sda_oen_q, sda_oen_d;
    logic [W-1:0]   byte_ext;

    logic sda_meta_q, sda_sync_q, sda_last_q;
    logic scl_meta_q, scl_sync_q, scl_last_q;
    logic scl_rise, scl_fall, start_det, stop_det, last_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_last_q <= 1'b1;
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_last_q <= 1'b1;
        end else begin
            sda_meta_q <= sda_in;
            sda_sync_q <= sda_meta_q;
            sda_last_q <= sda_sync_q;
            scl_meta_q <= scl_in;
            scl_sync_q <= scl_meta_q;
            scl_last_q <= scl_sync_q;
        end
    end

    assign scl_rise  = scl_sync_q & ~scl_last_q;
    assign scl_fall  = ~scl_sync_q & scl_last_q;
    assign start_det = scl_sync_q & scl_last_q & sda_last_q & ~sda_sync_q;
    assign stop_det  = scl_sync_q & scl_last_q & ~sda_last_q & sda_sync_q;
    assign last_byte = (byte_cnt_q == 2'(DATA_BYTES - 1));

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sda_oen_d  = sda_oen_q;
        byte_ext   = W'(shift_q);

        // Advance one clk after the strobe so wr_en sees the pointer it was aimed at.
        if (wr_en_q && AutoInc) reg_addr_d = reg_addr_q + 8'd1;

        if (!enable) begin
            state_d    = IDLE;
            sda_oen_d  = 1'b1;
            busy_d     = 1'b0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
        end else if (start_det) begin
            state_d    = ADDR;
            sda_oen_d  = 1'b1;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
        end else if (stop_det) begin
            state_d   = IDLE;
            sda_oen_d = 1'b1;
            busy_d    = 1'b0;
            done_d    = busy_q;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_sync_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        if (state_q == ADDR) begin
                            if (shift_q[7:1] == chip_id) begin
                                state_d   = ADDR_ACK;
                                sda_oen_d = 1'b0;
                                busy_d    = 1'b1;
                                rw_d      = shift_q[0];
                            end else begin
                                state_d   = WAIT_STOP;
                                sda_oen_d = 1'b1;
                            end
                        end else if (state_q == PTR) begin
                            state_d    = PTR_ACK;
                            sda_oen_d  = 1'b0;
                            reg_addr_d = shift_q;
                        end else begin
                            state_d   = WDATA_ACK;
                            sda_oen_d = 1'b0;
                            wr_data_d = (wr_data_q << 8) | byte_ext;
                            if (last_byte) begin
                                wr_en_d    = 1'b1;
                                byte_cnt_d = '0;
                            end else begin
                                byte_cnt_d = byte_cnt_q + 2'd1;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            state_d   = RDATA;
                            tx_d      = rd_data;
                            sda_oen_d = rd_data[W-1];
                        end else begin
                            state_d   = PTR;
                            sda_oen_d = 1'b1;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        state_d   = WDATA;
                        sda_oen_d = 1'b1;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        tx_d = tx_q << 1;
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = RDATA_ACK;
                            sda_oen_d = 1'b1;
                            bit_cnt_d = '0;
                            if (last_byte) begin
                                byte_cnt_d = '0;
                                if (AutoInc) reg_addr_d = reg_addr_q + 8'd1;
                            end else begin
                                byte_cnt_d = byte_cnt_q + 2'd1;
                            end
                        end else begin
                            sda_oen_d = tx_q[W-2];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        ack_d = ~sda_sync_q;
                    end else if (scl_fall) begin
                        if (ack_q) begin
                            state_d = RDATA;
                            if (byte_cnt_q == 2'd0) begin
                                tx_d      = rd_data;
                                sda_oen_d = rd_data[W-1];
                            end else begin
                                sda_oen_d = tx_q[W-1];
                            end
                        end else begin
                            state_d   = WAIT_STOP;
                            sda_oen_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            tx_q       <= '0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            reg_addr_q <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sda_oen_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            reg_addr_q <= reg_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sda_oen_q  <= sda_oen_d;
        end
    end

    assign sda_out  = 1'b0;
    assign scl_out  = 1'b0;
    assign scl_oen  = 1'b1;
    assign sda_oen  = sda_oen_q;
    assign reg_addr = reg_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_en    = wr_en_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged I2C master, register-file environment, word-level reference model.
`timescale 1ns/1ps
module tb_i2c_reg_target;
    localparam int DB = 2;
    localparam int T  = 50;
`ifdef I2C_TARGET_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [6:0]  chip_id = 7'h0F;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        seed_en = 1'b0;
    wire         sda_bus;
    logic        sda_out, scl_out, sda_oen, scl_oen, wr_en, busy, done;
    logic [7:0]  reg_addr;
    logic [15:0] rd_data, wr_data;

    logic [15:0] regs  [256];
    logic [15:0] mem_m [256];
    logic [7:0]  ptr_m = 8'h00;
    logic [7:0]  wbuf  [8];
    logic [7:0]  rexp  [8];
    logic [23:0] exp_wr[$];
    logic [23:0] got_wr[$];
    int          done_cnt = 0;
    int          oen_low_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign sda_bus = sda_m & (sda_oen | sda_out);
    assign rd_data = regs[reg_addr];

    i2c_reg_target #(.DATA_BYTES(DB)) dut (
        .clk(clk), .reset(reset), .enable(enable), .chip_id(chip_id),
        .sda_in(sda_bus), .scl_in(scl_m),
        .sda_out(sda_out), .scl_out(scl_out), .sda_oen(sda_oen), .scl_oen(scl_oen),
        .reg_addr(reg_addr), .rd_data(rd_data), .wr_data(wr_data), .wr_en(wr_en),
        .busy(busy), .done(done)
    );

    always @(posedge clk) begin
        if (seed_en) begin
            for (int i = 0; i < 256; i++) regs[i] <= mem_m[i];
        end else if (wr_en) begin
            regs[reg_addr] <= wr_data;
        end
    end

    always @(negedge clk) begin
        if (wr_en) got_wr.push_back({reg_addr, wr_data});
        if (done) done_cnt++;
        if (!sda_oen) oen_low_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---- bus master ----
    task automatic clk_bit(input logic b, output logic s);
        #T; sda_m = b;
        #T; scl_m = 1'b1;
        #T; s = sda_bus;
        #T; scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        #T; sda_m = 1'b1;
        #T; scl_m = 1'b1;
        #T; sda_m = 1'b0;
        #T; scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        #T; sda_m = 1'b0;
        #T; scl_m = 1'b1;
        #T; sda_m = 1'b1;
        #T;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic send_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(~send_ack, s);
    endtask

    // ---- reference model: words, a pointer, and the byte order on the wire ----
    task automatic model_write(input logic [7:0] p, input int n);
        ptr_m = p;
        for (int k = 0; k + DB <= n; k += DB) begin
            exp_wr.push_back({ptr_m, wbuf[k], wbuf[k+1]});
            mem_m[ptr_m] = {wbuf[k], wbuf[k+1]};
            if (AUTOINC) ptr_m = ptr_m + 8'd1;
        end
    endtask

    task automatic model_read(input int n);
        for (int i = 0; i < n; i++) begin
            rexp[i] = (i % DB == 0) ? mem_m[ptr_m][15:8] : mem_m[ptr_m][7:0];
            if (i % DB == DB - 1 && AUTOINC) ptr_m = ptr_m + 8'd1;
        end
    endtask

    task automatic cmp_wr();
        chk("wr_count", got_wr.size(), exp_wr.size());
        while (got_wr.size() > 0 && exp_wr.size() > 0) chk("wr_event", got_wr.pop_front(), exp_wr.pop_front());
        got_wr.delete();
        exp_wr.delete();
    endtask

    task automatic do_write(input logic [6:0] addr, input logic [7:0] p, input int n);
        logic ack;
        int   d0, o0;
        d0 = done_cnt;
        o0 = oen_low_cnt;
        i2c_start();
        write_byte({addr, 1'b0}, ack);
        if (addr == chip_id) begin
            chk("addr_ack", ack, 1);
            write_byte(p, ack);
            chk("ptr_ack", ack, 1);
            for (int i = 0; i < n; i++) begin
                write_byte(wbuf[i], ack);
                chk("data_ack", ack, 1);
            end
            i2c_stop();
            model_write(p, n);
            chk("done_pulse", done_cnt - d0, 1);
        end else begin
            chk("foreign_nack", ack, 0);
            chk("foreign_busy", busy, 0);
            i2c_stop();
            chk("foreign_oen", oen_low_cnt - o0, 0);
            chk("foreign_done", done_cnt - d0, 0);
        end
        chk("busy_after_stop", busy, 0);
        chk("reg_addr", reg_addr, ptr_m);
        cmp_wr();
    endtask

    task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n);
        logic       ack;
        logic [7:0] d;
        int         d0;
        d0 = done_cnt;
        i2c_start();
        if (set_ptr) begin
            write_byte(8'h1E, ack);
            chk("wr_addr_ack", ack, 1);
            write_byte(p, ack);
            chk("ptr_ack", ack, 1);
            ptr_m = p;
            i2c_start();
        end
        write_byte(8'h1F, ack);
        chk("rd_addr_ack", ack, 1);
        model_read(n);
        for (int i = 0; i < n; i++) begin
            read_byte(i != n - 1, d);
            chk("rd_byte", d, rexp[i]);
        end
        i2c_stop();
        chk("done_pulse", done_cnt - d0, 1);
        chk("busy_after_stop", busy, 0);
        chk("reg_addr", reg_addr, ptr_m);
        cmp_wr();
    endtask

    initial begin
        logic       s, ack;
        int         d0, kind, n;
        logic [7:0] p;

        for (int i = 0; i < 256; i++) mem_m[i] = 16'($urandom);
        mem_m[0] = 16'hA1A1;
        mem_m[1] = 16'hB2B2;
        seed_en = 1'b1;
        repeat (3) @(posedge clk);
        seed_en = 1'b0;
        @(negedge clk);
        chk("rst_sda_oen", sda_oen, 1);
        chk("rst_scl_oen", scl_oen, 1);
        chk("rst_outs", {sda_out, scl_out}, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_strobes", {wr_en, busy, done}, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // pointer write then repeated-START read of one word
        do_read(1'b1, 8'h00, 2);
        // block read across a word boundary
        do_read(1'b1, 8'h00, 4);

        // reset while the target drives the second read bit
        d0 = done_cnt;
        i2c_start();
        write_byte(8'h1E, ack);
        write_byte(8'h00, ack);
        ptr_m = 8'h00;
        i2c_start();
        write_byte(8'h1F, ack);
        chk("rst_rd_ack", ack, 1);
        clk_bit(1'b1, s);
        chk("rst_rd_bit7", s, mem_m[0][15]);
        #T; sda_m = 1'b1;
        #T; scl_m = 1'b1;
        #T;
        chk("rst_rd_bit6", sda_bus, mem_m[0][14]);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_sda_oen", sda_oen, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_reg_addr", reg_addr, 0);
        @(negedge clk) reset = 1'b0;
        #T; scl_m = 1'b0;
        i2c_stop();
        chk("midrst_done", done_cnt - d0, 0);
        do_write(7'h0F, 8'h00, 0);

        // foreign address
        do_write(7'h10, 8'h00, 0);

        // write across the pointer wrap
        wbuf[0] = 8'h12; wbuf[1] = 8'h34; wbuf[2] = 8'h56; wbuf[3] = 8'h78;
        do_write(7'h0F, 8'hFF, 4);

        // partial trailing word is dropped
        wbuf[0] = 8'hDE; wbuf[1] = 8'hAD; wbuf[2] = 8'hBE;
        do_write(7'h0F, 8'h10, 3);

        // enable drop while the target drives a data ACK
        d0 = done_cnt;
        i2c_start();
        write_byte(8'h1E, ack);
        write_byte(8'h05, ack);
        ptr_m = 8'h05;
        for (int i = 7; i >= 0; i--) clk_bit(i[0], s);
        #(2*T);
        chk("en_ack_driven", sda_oen, 0);
        @(negedge clk) enable = 1'b0;
        @(posedge clk);
        #1;
        chk("en_sda_oen", sda_oen, 1);
        chk("en_busy", busy, 0);
        @(negedge clk) enable = 1'b1;
        i2c_stop();
        chk("en_done", done_cnt - d0, 0);
        chk("en_reg_addr", reg_addr, ptr_m);
        cmp_wr();

        // randomized traffic
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 3);
            p    = (t % 4 == 0) ? 8'($urandom_range(252, 255)) : 8'($urandom_range(0, 255));
            n    = $urandom_range(1, 5);
            for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom_range(0, 255));
            case (kind)
                0:       do_write(7'h0F, p, n);
                1:       do_read(1'b1, p, n);
                2:       do_read(1'b0, p, n);
                default: do_write(7'($urandom_range(16, 127)), p, n);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_reg_target.md
I2C_REG_TARGET -- requirements
Module: i2c_reg_target

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 2, giving the bytes per register word (legal values 1 or 2, MSB first on the bus).
REQ-002 SHALL have port clk  input  1  system clock; the block SHALL use this one clock only and SHALL work for clk >= 8x SCL frequency.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  1 = respond on the bus; 0 = ignore the bus.
REQ-005 SHALL have port chip_id  input  7  7-bit target address.
REQ-006 SHALL have port sda_in / scl_in  input  1 each  raw bus levels.
REQ-007 SHALL have port sda_out / scl_out  output  1 each  both tied to 0 (open drain).
REQ-008 SHALL have port sda_oen / scl_oen  output  1 each  0 = pull the line low; scl_oen is held at 1 (no clock stretching).
REQ-009 SHALL have port reg_addr  output  8  register pointer.
REQ-010 SHALL have port rd_data  input  8*DATA_BYTES  word at reg_addr; it must be valid 1 clk after reg_addr changes.
REQ-011 SHALL have port wr_data  output  8*DATA_BYTES  assembled write word.
REQ-012 SHALL have port wr_en  output  1  one-clk write strobe.
REQ-013 SHALL have port busy  output  1  high from an address match until STOP.
REQ-014 SHALL have port done  output  1  one-clk pulse that ends an addressed transaction.

Function
REQ-015 SHALL pass sda_in and scl_in through a 2-flop synchronizer; SCL edges SHALL be detected from the synchronized values.
REQ-016 SHALL detect START as synced SDA 1->0 while SCL is high, and STOP as synced SDA 0->1 while SCL is high.
REQ-017 SHALL sample SDA on SCL rise and SHALL change sda_oen only on SCL fall.
REQ-018 SHALL use FSM states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-019 SHALL enter ADDR on START (including repeated START) from any state, clearing the bit and byte counters.
REQ-020 ADDR: after 8 bits, if bits[7:1] == chip_id, SHALL drive ACK (sda_oen=0) for one SCL period and set busy; otherwise SHALL go to WAIT_STOP with SDA released.
REQ-021 For an address with R/W=0, the first byte SHALL load reg_addr (PTR, ACKed), and the following bytes SHALL fill wr_data MSB first (WDATA, each ACKed).
REQ-022 After DATA_BYTES write bytes, wr_en SHALL pulse for 1 clk with the current reg_addr and wr_data, then the pointer SHALL advance per REQ-030.
REQ-023 For an address with R/W=1, the block SHALL capture rd_data at the SCL fall that ends ADDR_ACK and SHALL shift it out MSB first (RDATA).
REQ-024 RDATA_ACK: on master ACK, the block SHALL send the next byte; after the last byte of a word it SHALL advance the pointer and recapture rd_data at the ACK-ending SCL fall; on master NACK it SHALL release SDA and go to WAIT_STOP.
REQ-025 A partial write word (fewer than DATA_BYTES bytes before STOP or START) SHALL be discarded, with no wr_en.
REQ-026 On STOP from any state, the FSM SHALL go to IDLE and busy SHALL clear; done SHALL pulse only if busy was set.
REQ-027 The pointer SHALL wrap from 8'hFF to 8'h00.
REQ-028 When enable=0, the FSM SHALL go to IDLE, sda_oen SHALL be 1, and busy SHALL be 0 on the next clk, including mid-transaction.

Reset
REQ-029 With reset=1 at a clk edge, all of the following SHALL hold, including mid-transaction (SDA released on the next clk):
- FSM = IDLE;
- sda_oen = 1, scl_oen = 1, sda_out = 0, scl_out = 0;
- reg_addr = 0, wr_data = 0;
- wr_en = 0, busy = 0, done = 0;
- synchronizer flops = 1.

Configuration
REQ-030 Macro I2C_TARGET_AUTOINC_EN sets pointer behaviour:
- defined: reg_addr SHALL increment (with wrap) after every completed read or write word;
- undefined: reg_addr SHALL stay at the value written in PTR for the whole transaction, so repeated words read or write the same register.

Verification (chip_id=0x0F, DATA_BYTES=2, rd_data map 0x00->16'hA1A1, 0x01->16'hB2B2, AUTOINC defined)
REQ-031 Sequence START, 0x1E, 0x00, repeated START, 0x1F, read 2 bytes, NACK, STOP -> three ACKs, bytes 0xA1 0xA1, one done pulse, busy low after STOP.
REQ-032 Set pointer 0x00, then block read of 4 bytes (ACK, ACK, ACK, NACK) -> bytes 0xA1 0xA1 0xB2 0xB2, and reg_addr = 0x02 at STOP.
REQ-033 Sequence START, 0x1E, 0xFF, 0x12, 0x34, 0x56, 0x78, STOP -> wr_en with (0xFF, 0x1234) then (0x00, 0x5678); the 0xFF->0x00 wrap is checked.
REQ-034 Address 0x10 with R/W=0 -> no ACK, sda_oen stays 1, busy stays 0, no done pulse.
REQ-035 Assert reset during the second data bit of RDATA -> sda_oen=1 and busy=0 on the next clk; a following transaction to 0x0F is ACKed normally.
REQ-036 With I2C_TARGET_AUTOINC_EN undefined, the REQ-032 stimulus -> bytes 0xA1 0xA1 0xA1 0xA1, and reg_addr stays 0x00.
